// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: single-cycle logic/arith/compare ops and an
// iterative one-bit-per-cycle shifter, with valid/ready on both sides.
module alu_exec_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  ALUCtrl,
   input  logic        Sign,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_overflow,
   output logic        out_illegal
);

   localparam logic [4:0] OpAdd = 5'd0;
   localparam logic [4:0] OpSub = 5'd1;
   localparam logic [4:0] OpAnd = 5'd2;
   localparam logic [4:0] OpOr  = 5'd3;
   localparam logic [4:0] OpXor = 5'd4;
   localparam logic [4:0] OpNor = 5'd5;
   localparam logic [4:0] OpSll = 5'd6;
   localparam logic [4:0] OpSrl = 5'd7;
   localparam logic [4:0] OpSra = 5'd8;
   localparam logic [4:0] OpSlt = 5'd9;

   typedef enum logic [0:0] {StIdle, StShift} state_e;
   typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

   state_e      state_q, state_d;
   shift_e      sh_op_q, sh_op_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;
   logic        ill_q, ill_d;

   logic [31:0] sum, diff, comb_result, work_step;
   logic        comb_ovf, comb_ill, is_shift, less, accept;
   shift_e      new_sh_op;

   // Single-cycle result for the op currently presented on the input side.
   always_comb begin
      sum         = in_a + in_b;
      diff        = in_a - in_b;
      less        = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
      comb_result = '0;
      comb_ovf    = 1'b0;
      comb_ill    = 1'b0;
      is_shift    = 1'b0;
      new_sh_op   = ShSll;
      case (ALUCtrl)
         OpAdd: begin
            comb_result = sum;
            comb_ovf    = Sign & (in_a[31] == in_b[31]) & (sum[31] != in_a[31]);
         end
         OpSub: begin
            comb_result = diff;
            comb_ovf    = Sign & (in_a[31] != in_b[31]) & (diff[31] != in_a[31]);
         end
         OpAnd: comb_result = in_a & in_b;
         OpOr:  comb_result = in_a | in_b;
         OpXor: comb_result = in_a ^ in_b;
         OpNor: comb_result = ~(in_a | in_b);
         // Shift result here only matters for a zero amount, where it is B itself.
         OpSll: begin
            comb_result = in_b;
            is_shift    = 1'b1;
            new_sh_op   = ShSll;
         end
         OpSrl: begin
            comb_result = in_b;
            is_shift    = 1'b1;
            new_sh_op   = ShSrl;
         end
         OpSra: begin
            comb_result = in_b;
            is_shift    = 1'b1;
            new_sh_op   = ShSra;
         end
         OpSlt: comb_result = {31'd0, less};
         default: comb_ill = 1'b1;
      endcase
   end

   // One-bit step of the iterative shifter.
   always_comb begin
      work_step = work_q;
      case (sh_op_q)
         ShSll:   work_step = {work_q[30:0], 1'b0};
         ShSrl:   work_step = {1'b0, work_q[31:1]};
         ShSra:   work_step = {work_q[31], work_q[31:1]};
         default: work_step = work_q;
      endcase
   end

   // Handshake, FSM and output-register next state.
   always_comb begin
      state_d     = state_q;
      sh_op_d     = sh_op_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      ill_d       = ill_q;

      in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !reset;
      accept   = in_valid && in_ready;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_shift && (in_a[4:0] != 5'd0)) begin
                  work_d  = in_b;
                  sh_op_d = new_sh_op;
                  cnt_d   = in_a[4:0];
                  state_d = StShift;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = comb_result;
                  zero_d      = (comb_result == 32'd0);
                  ovf_d       = comb_ovf;
                  ill_d       = comb_ill;
               end
            end
         end
         StShift: begin
            work_d = work_step;
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               // The output register is free here: entry required it empty or draining.
               out_valid_d = 1'b1;
               result_d    = work_step;
               zero_d      = (work_step == 32'd0);
               ovf_d       = 1'b0;
               ill_d       = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         sh_op_q     <= ShSll;
         work_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_op_q     <= sh_op_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         ill_q       <= ill_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_result   = result_q;
   assign out_zero     = zero_q;
   assign out_overflow = ovf_q;
   assign out_illegal  = ill_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized
// ops checked against an arithmetic reference model.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  ALUCtrl;
   logic        Sign;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_overflow;
   logic        out_illegal;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_exec_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ALUCtrl      (ALUCtrl),
      .Sign         (Sign),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_overflow (out_overflow),
      .out_illegal  (out_illegal)
   );

   // Reference model: op semantics written directly as integer arithmetic.
   function automatic void ref_model(input logic [4:0] op, input logic s,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ov,
                                     output logic il);
      longint sa, sb, wide;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 32'd0;
      ov = 1'b0;
      il = 1'b0;
      case (op)
         5'd0: begin
            wide = sa + sb;
            r    = a + b;
            ov   = s && ((wide > 64'sh7FFFFFFF) || (wide < -64'sh80000000));
         end
         5'd1: begin
            wide = sa - sb;
            r    = a - b;
            ov   = s && ((wide > 64'sh7FFFFFFF) || (wide < -64'sh80000000));
         end
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: r = ~(a | b);
         5'd6: r = b << a[4:0];
         5'd7: r = b >> a[4:0];
         5'd8: r = $unsigned($signed(b) >>> a[4:0]);
         5'd9: r = (s ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
         default: il = 1'b1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic s, input logic [31:0] a,
                        input logic [31:0] b);
      in_valid = 1'b1;
      ALUCtrl  = op;
      Sign     = s;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic test_reset();
      int stale;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ALUCtrl   = '0;
      Sign      = 1'b0;
      in_a      = '0;
      in_b      = '0;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready_initial: got %b exp 0", in_ready);
      end
      tick();
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b exp 1", in_ready);
      end
      // Start an 8-bit shift, then reset in the middle of it.
      drive(5'd6, 1'b0, 32'd8, 32'h0000_00FF);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_shift_ready: got %b exp 0", in_ready);
      end
      tick();
      vectors++;
      if ({out_valid, out_result, out_zero, out_overflow, out_illegal, in_ready} !== 37'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b i=%b rdy=%b exp all 0",
                  out_valid, out_result, out_zero, out_overflow, out_illegal, in_ready);
      end
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_after_release: got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
      end
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid !== 1'b0) stale++;
      end
      vectors++;
      if (stale != 0) begin
         miscompares++;
         $display("FAIL reset_no_stale: got %0d valid cycles exp 0", stale);
      end
   endtask

   task automatic test_add_overflow();
      out_ready = 1'b1;
      drive(5'd0, 1'b1, 32'h7FFF_FFFF, 32'd1);
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_result, out_overflow, out_zero, out_illegal} !==
          {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL add_signed_ovf: got v=%b r=%h o=%b z=%b exp v=1 r=80000000 o=1 z=0",
                  out_valid, out_result, out_overflow, out_zero);
      end
      drive(5'd0, 1'b0, 32'h7FFF_FFFF, 32'd1);
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_result, out_overflow} !== {1'b1, 32'h8000_0000, 1'b0}) begin
         miscompares++;
         $display("FAIL add_unsigned_no_ovf: got v=%b r=%h o=%b exp v=1 r=80000000 o=0",
                  out_valid, out_result, out_overflow);
      end
      tick();
   endtask

   task automatic test_slt();
      out_ready = 1'b1;
      drive(5'd9, 1'b1, 32'hFFFF_FFFF, 32'd1);
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_result, out_zero} !== {1'b1, 32'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL slt_signed: got v=%b r=%h z=%b exp v=1 r=1 z=0",
                  out_valid, out_result, out_zero);
      end
      drive(5'd9, 1'b0, 32'hFFFF_FFFF, 32'd1);
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_result, out_zero} !== {1'b1, 32'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL slt_unsigned: got v=%b r=%h z=%b exp v=1 r=0 z=1",
                  out_valid, out_result, out_zero);
      end
      tick();
   endtask

   task automatic test_sra_latency();
      out_ready = 1'b1;
      drive(5'd8, 1'b0, 32'd4, 32'h8000_0000);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sra_busy_cycle%0d: got rdy=%b v=%b exp rdy=0 v=0",
                     i, in_ready, out_valid);
         end
         tick();
      end
      vectors++;
      if ({out_valid, out_result, out_overflow, out_illegal} !==
          {1'b1, 32'hF800_0000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL sra_result: got v=%b r=%h exp v=1 r=f8000000", out_valid, out_result);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL sra_ready_return: got %b exp 1", in_ready);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, held;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom;
         drive(5'd4, 1'b0, a, b);
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_ready%0d: got %b exp 1", i, in_ready);
         end
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_result !== (a ^ b)) begin
            miscompares++;
            $display("FAIL stream_result%0d: got v=%b r=%h exp v=1 r=%h",
                     i, out_valid, out_result, a ^ b);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      held      = a ^ b;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got v=%b r=%h rdy=%b exp v=1 r=%h rdy=0",
                     i, out_valid, out_result, in_ready, held);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_drain: got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive(5'h1F, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_result, out_illegal, out_zero, out_overflow} !==
          {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL illegal_op: got v=%b r=%h i=%b z=%b o=%b exp v=1 r=0 i=1 z=1 o=0",
                  out_valid, out_result, out_illegal, out_zero, out_overflow);
      end
      tick();
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic        s, exp_ov, exp_il;
      logic [31:0] a, b, exp_r;
      int          waited, exp_lat, r;
      out_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 11);
         op = (r >= 10) ? 5'($urandom_range(10, 31)) : 5'(r);
         s  = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) a[4:0] = 5'd0;
         ref_model(op, s, a, b, exp_r, exp_ov, exp_il);
         exp_lat = ((op >= 5'd6) && (op <= 5'd8)) ? int'(a[4:0]) : 0;
         out_ready = 1'b1;
         drive(op, s, a, b);
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rand%0d_ready: got %b exp 1", n, in_ready);
         end
         tick();
         in_valid = 1'b0;
         waited = 0;
         while (out_valid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
         end
         vectors++;
         if (out_valid !== 1'b1 || waited != exp_lat) begin
            miscompares++;
            $display("FAIL rand%0d_latency op=%0d: got v=%b wait=%0d exp v=1 wait=%0d",
                     n, op, out_valid, waited, exp_lat);
         end
         vectors++;
         if ({out_result, out_overflow, out_illegal, out_zero} !==
             {exp_r, exp_ov, exp_il, (exp_r == 32'd0)}) begin
            miscompares++;
            $display("FAIL rand%0d_result op=%0d s=%b a=%h b=%h: got r=%h o=%b i=%b z=%b exp r=%h o=%b i=%b z=%b",
                     n, op, s, a, b, out_result, out_overflow, out_illegal, out_zero,
                     exp_r, exp_ov, exp_il, (exp_r == 32'd0));
         end
         if ($urandom_range(0, 2) == 0) begin
            out_ready = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            vectors++;
            if (out_valid !== 1'b1 || out_result !== exp_r || in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL rand%0d_stall: got v=%b r=%h rdy=%b exp v=1 r=%h rdy=0",
                        n, out_valid, out_result, in_ready, exp_r);
            end
         end
      end
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_slt();
      test_sra_latency();
      test_back_to_back();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that sits directly downstream of the ALU control decoder. It consumes the decoder's `ALUCtrl`/`Sign` pair together with two 32-bit operands over a valid/ready handshake. It produces a registered result with zero, overflow and illegal-op flags. Logic ops, add/sub and compares complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter controlled by a small FSM.

## Interface
Parameters:
- none; datapath fixed at 32 bits, shift amount 5 bits.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  stage can accept; transfer when `in_valid && in_ready`.
- `ALUCtrl`  in  5  op code from the decoder.
- `Sign`  in  1  1 = signed semantics, 0 = unsigned.
- `in_a`  in  32  operand A; for shifts, `in_a[4:0]` is the shift amount.
- `in_b`  in  32  operand B; for shifts, the value shifted.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid && out_ready`.
- `out_result`  out  32  result.
- `out_zero`  out  1  `out_result == 0`.
- `out_overflow`  out  1  signed add/sub overflow.
- `out_illegal`  out  1  `ALUCtrl` outside 0..9.

## Operation
- Op encoding:
  - 0 add: A+B
  - 1 sub: A−B
  - 2 and
  - 3 or
  - 4 xor
  - 5 nor
  - 6 sll: B<<A[4:0]
  - 7 srl: B>>A[4:0], logical
  - 8 sra: B>>>A[4:0], arithmetic
  - 9 slt: result 1 or 0, 32-bit zero-extended
- Codes 10–31: result 0, `out_illegal`=1, overflow 0. These complete in one cycle.
- Add/sub: modulo 2^32 result.
  - `out_overflow` = 1 only when `Sign`=1 and signed overflow occurs: operand signs equal (for add) or differ (for sub) and the result sign differs from A.
  - `Sign`=0 never flags overflow.
  - Result is written regardless of overflow; trapping is handled downstream.
- slt compare:
  - `Sign`=1: two's-complement compare.
  - `Sign`=0: unsigned compare.
- For shifts, `Sign` is ignored; sra always sign-fills from B[31].
- `out_overflow` is 0 for all non-add/sub ops. `out_zero` is computed from the final result.
- FSM states:
  - IDLE: accepts. A non-shift op, or a shift with amount 0, loads the output register directly and the FSM stays in IDLE. A shift with amount k>0 latches B, op and k, then moves to SHIFT.
  - SHIFT: shifts the working register by 1 bit per cycle and decrements k. When k reaches 0, loads the output register and moves to IDLE.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready) && !reset.
- Output register holds all outputs stable while `out_valid && !out_ready`.
- `out_valid` clears on `out_ready` unless a new result loads in the same cycle.

## Timing
- Reset (synchronous) values:
  - state = IDLE
  - `out_valid`=0, `out_result`=0, `out_zero`=0, `out_overflow`=0, `out_illegal`=0
  - `in_ready`=0 while `reset`=1; `in_ready`=1 in the first cycle after release.
- Reset asserted mid-SHIFT aborts the operation. No result is produced.
- Latency, measured from accept edge N:
  - Non-shift op or zero-amount shift: `out_valid`=1 after edge N, i.e. 1 cycle.
  - Shift by k>0: `out_valid`=1 after edge N+k, i.e. k+1 cycles.
- Throughput:
  - Back-to-back single-cycle ops with `out_ready` held at 1 sustain 1 op per cycle, no bubbles.
  - Accept and drain in the same cycle is legal; the new result replaces the drained one.
- `in_ready`=0 throughout SHIFT. It returns to 1 in the cycle after the shift result loads, provided the output is free or draining.
- Output backpressure: when `out_valid`=1 and `out_ready`=0, `in_ready`=0 and nothing is overwritten.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready`.

## Test plan
- Reset: assert `reset` for 2 cycles during an 8-bit shift.
  - Required: all outputs 0, `in_ready`=0 during reset, then 1; no stale result appears.
- Signed add overflow: `ALUCtrl`=0, `Sign`=1, A=0x7FFFFFFF, B=1.
  - Required: one cycle later result 0x80000000, overflow=1, zero=0.
  - Same operands with `Sign`=0: overflow=0.
- slt: A=0xFFFFFFFF, B=1.
  - `Sign`=1: result 1.
  - `Sign`=0: result 0, zero=1.
- sra: A=4, B=0x80000000.
  - Required: `out_valid` 5 cycles after accept, result 0xF8000000, `in_ready`=0 for the 4 intervening cycles.
- Streaming and stall:
  - 4 back-to-back xor ops with `out_ready`=1 produce 4 results in 4 consecutive cycles.
  - Then hold `out_ready`=0 for 3 cycles: result stays stable and `in_ready`=0.
- Illegal op: `ALUCtrl`=0x1F.
  - Required: result 0, illegal=1, zero=1, 1-cycle latency.
